serial_subtractor: RTL

Bit-serial two's-complement subtractor computing q = a - b - bin. It processes one bit per clock, LSB first, over DATA_WIDTH cycles. Valid/ready handshakes are used on both the operand side and the result side. It provides the decrement/difference path next to the combinational ripple adder, for tape-head moves and counter rollback in the Turing-machine datapath, where area matters more than latency.

---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_bit_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared FSM encodings and sizing helper for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width; never below one bit so tiny widths still elaborate.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_bit_subtractor.sv
// ============================================================================
// Module      : bit_subtractor
// Description : Combinational one-bit full subtractor (x - y - bin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor q = a - b - bin, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  bout,
    output logic                  zero
);

    localparam int                c_cnt_w = cnt_width(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_br;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_d;
    logic                  w_bout;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_res_next;

    bit_subtractor u_bit_subtractor (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last     = (r_state == ST_RUN) && (r_cnt == c_last);
    assign w_res_next = {w_d, r_res[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Handshake flags come straight from the state register: no input-to-output path.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            q     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_br  <= bin;
                r_res <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_next;
                r_br  <= w_bout;
                r_cnt <= r_cnt + 1'b1;
                // Visible result only updates on the final bit; it holds through RUN.
                if (w_last) begin
                    q    <= w_res_next;
                    bout <= w_bout;
                    zero <= (w_res_next == '0);
                end
            end
        end
    end

endmodule

`default_nettype wire
